// File: rtl/kamus_pkg.sv
// Shared types for the kamus memory stage: operation encodings, access sizes,
// FSM states and small decode helpers.
package kamus_pkg;

    typedef enum logic [5:0] {
        OP_ADD  = 6'd0,
        OP_SUB  = 6'd1,
        OP_AND  = 6'd2,
        OP_OR   = 6'd3,
        OP_XOR  = 6'd4,
        OP_SLL  = 6'd5,
        OP_SRL  = 6'd6,
        OP_SRA  = 6'd7,
        OP_SLT  = 6'd8,
        OP_SLTU = 6'd9,
        OP_LB   = 6'd16,
        OP_LH   = 6'd17,
        OP_LW   = 6'd18,
        OP_LBU  = 6'd19,
        OP_LHU  = 6'd20,
        OP_SB   = 6'd24,
        OP_SH   = 6'd25,
        OP_SW   = 6'd26
    } operation_e;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} mem_state_e;

    function automatic logic is_mem_op(operation_e op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic mem_size_e mem_size(operation_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_unsigned_load(operation_e op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_misaligned(mem_size_e size, logic [1:0] a);
        case (size)
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/kamus_lsu_align.sv
// Byte-lane steering for stores and load-data extraction / extension.
module kamus_lsu_align
    import kamus_pkg::*;
(
    input  mem_size_e   size,
    input  logic        uns,
    input  logic [1:0]  a,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[8*a +: 8];
        half_v = a[1] ? rdata[31:16] : rdata[15:0];
        be     = 4'b1111;
        wdata  = rs2;
        ldata  = rdata;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << a;
                wdata = {4{rs2[7:0]}};
                ldata = {{24{~uns & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                // half accesses only look at a[1]; a[0] is aligned away
                be    = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2[15:0]}};
                ldata = {{16{~uns & half_v[15]}}, half_v};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/kamus_mem.sv
// Memory stage: L1D req/gnt/rvalid access, lane steering, registered write-back.
// Optional MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of issuing them.
module kamus_mem
    import kamus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [5:0]        operation_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              l1d_wr_en_i,
    input  logic              regfile_wr_en_i,
    input  logic [1:0]        wb_mux_sel_i,
    output logic              dmem_req_o,
    input  logic              dmem_gnt_i,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_addr_o,
    output logic              wb_regfile_wr_en_o,
    output logic [1:0]        wb_mux_sel_o,
    output logic [DATA_W-1:0] wb_alu_result_o,
    output logic [DATA_W-1:0] wb_load_data_o,
    output logic              misaligned_o
);

    mem_state_e        state_q, state_d;
    operation_e        op_in, op_q;
    logic              mis_in;
    logic [DATA_W-1:0] res_q, rs2_q;
    logic [4:0]        rd_q;
    logic              st_q, rf_we_q;
    logic [1:0]        mux_q;
    logic              wb_rf_we_q;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata, ldata;

    assign op_in = operation_e'(operation_i);

`ifdef MISALIGN_TRAP_EN
    assign mis_in = is_mem_op(op_in) && is_misaligned(mem_size(op_in), ex_result_i[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        ex_ready_o = 1'b0;
        dmem_req_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ex_ready_o = 1'b1;
                if (ex_valid_i && is_mem_op(op_in) && !mis_in) state_d = ST_REQ;
            end
            ST_REQ: begin
                dmem_req_o = 1'b1;
                if (dmem_gnt_i) state_d = ST_WAIT;
            end
            ST_WAIT: if (dmem_rvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    kamus_lsu_align u_align (
        .size  (mem_size(op_q)),
        .uns   (is_unsigned_load(op_q)),
        .a     (res_q[1:0]),
        .rs2   (rs2_q),
        .rdata (dmem_rdata_i),
        .be    (be),
        .wdata (wdata),
        .ldata (ldata)
    );

    // request-side outputs read zero whenever no request is live
    assign dmem_addr_o  = dmem_req_o ? {res_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_be_o    = dmem_req_o ? be : 4'b0000;
    assign dmem_we_o    = dmem_req_o & st_q;
    assign dmem_wdata_o = dmem_req_o ? wdata : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q            <= OP_ADD;
            res_q           <= '0;
            rs2_q           <= '0;
            rd_q            <= '0;
            st_q            <= 1'b0;
            rf_we_q         <= 1'b0;
            mux_q           <= '0;
            wb_valid_o      <= 1'b0;
            wb_rd_addr_o    <= '0;
            wb_rf_we_q      <= 1'b0;
            wb_mux_sel_o    <= '0;
            wb_alu_result_o <= '0;
            wb_load_data_o  <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: if (ex_valid_i) begin
                    op_q    <= op_in;
                    res_q   <= ex_result_i;
                    rs2_q   <= rs2_data_i;
                    rd_q    <= rd_addr_i;
                    st_q    <= l1d_wr_en_i;
                    rf_we_q <= regfile_wr_en_i;
                    mux_q   <= wb_mux_sel_i;
                    // ALU ops and trapped accesses retire straight from IDLE
                    if (!is_mem_op(op_in) || mis_in) begin
                        wb_valid_o      <= 1'b1;
                        wb_rd_addr_o    <= rd_addr_i;
                        wb_rf_we_q      <= regfile_wr_en_i & ~mis_in;
                        wb_mux_sel_o    <= wb_mux_sel_i;
                        wb_alu_result_o <= ex_result_i;
                    end
                end
                ST_WAIT: if (dmem_rvalid_i) begin
                    wb_valid_o      <= 1'b1;
                    wb_rd_addr_o    <= rd_q;
                    wb_rf_we_q      <= rf_we_q;
                    wb_mux_sel_o    <= mux_q;
                    wb_alu_result_o <= res_q;
                    wb_load_data_o  <= st_q ? '0 : ldata;
                end
                default: ;
            endcase
        end
    end

    assign wb_regfile_wr_en_o = wb_valid_o & wb_rf_we_q;

`ifdef MISALIGN_TRAP_EN
    logic wb_mis_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                             wb_mis_q <= 1'b0;
        else if (state_q == ST_IDLE && ex_valid_i) wb_mis_q <= mis_in;
        else if (state_q == ST_WAIT && dmem_rvalid_i) wb_mis_q <= 1'b0;
    end
    assign misaligned_o = wb_valid_o & wb_mis_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule
